// File: rtl/dcim_pkg.sv
// Shared types and sizing helpers for the digital compute-in-memory MAC array.
package dcim_pkg;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_READ,
        OP_MAC
    } op_kind_e;

    function automatic int qw_f(input int ww, input int xw,
                                input int nbank, input int gb);
        return ww + xw + $clog2(nbank) + gb;
    endfunction

endpackage

// File: rtl/dcim_adder_tree.sv
// N-input reduction of per-bank products, sign- or zero-extending each leaf.
module dcim_adder_tree #(
    parameter int N  = 16,
    parameter int IW = 19,
    localparam int OW = IW + $clog2(N)
) (
    input  logic            sgn_i,
    input  logic [N*IW-1:0] in_i,
    output logic [OW-1:0]   sum_o
);

    logic [OW-1:0] node [2*N];

    // Heap layout: leaves at N..2N-1, root at 1.
    always_comb begin
        for (int i = 0; i < 2 * N; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            if (sgn_i) begin
                node[N+i] = {{(OW-IW){in_i[i*IW+IW-1]}}, in_i[i*IW +: IW]};
            end else begin
                node[N+i] = {{(OW-IW){1'b0}}, in_i[i*IW +: IW]};
            end
        end
        for (int i = N - 1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i+1];
        end
        sum_o = node[1];
    end

endmodule

// File: rtl/dcim_mac_array.sv
// Banked weight memory with a two-stage multiply / adder-tree / accumulate path.
module dcim_mac_array
    import dcim_pkg::*;
#(
    parameter int NBANK = 16,
    parameter int NWORD = 4,
    parameter int WW    = 8,
    parameter int XW    = 11,
    parameter int GB    = 4,
    localparam int QW   = qw_f(WW, XW, NBANK, GB),
    localparam int BW   = $clog2(NBANK),
    localparam int AW   = $clog2(NWORD),
    localparam int PW   = WW + XW,
    localparam int SW   = PW + BW
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [BW-1:0]      BANKA,
    input  logic [AW-1:0]      ADRA,
    input  logic [WW-1:0]      D,
    input  logic               WEB,
    input  logic [BW-1:0]      BANKB,
    input  logic [AW-1:0]      ADRB,
    input  logic               REB,
    input  logic               ENCB,
    input  logic [NBANK*XW-1:0] XIN,
    input  logic               SGN,
    input  logic               ACC,
    output logic [QW-1:0]      Q,
    output logic               QV,
    output logic               OVF
);

    logic [WW-1:0]       mem_q [NBANK][NWORD];
    op_kind_e            op_d, op_q;
    logic                sgn_q, accf_q;
    logic [NBANK*PW-1:0] prod_d, prod_q;
    logic [WW-1:0]       rdat_q;
    logic [QW-1:0]       acc_d, acc_q, q_d, q_q;
    logic                qv_d, qv_q, ovf_d, ovf_q;
    logic [SW-1:0]       tree_sum;

    always_comb begin
        op_d = OP_NONE;
        if (!ENCB) begin
            op_d = OP_MAC;
        end else if (!REB) begin
            op_d = OP_READ;
        end
    end

    always_comb begin
        logic [WW-1:0] w;
        logic [XW-1:0] x;
        logic [PW-1:0] we, xe;
        prod_d = '0;
        for (int b = 0; b < NBANK; b++) begin
            w = mem_q[b][ADRB];
            x = XIN[b*XW +: XW];
            if (SGN) begin
                we = {{XW{w[WW-1]}}, w};
                xe = {{WW{x[XW-1]}}, x};
            end else begin
                we = {{XW{1'b0}}, w};
                xe = {{WW{1'b0}}, x};
            end
            prod_d[b*PW +: PW] = we * xe;
        end
    end

    dcim_adder_tree #(
        .N  (NBANK),
        .IW (PW)
    ) u_tree (
        .sgn_i (sgn_q),
        .in_i  (prod_q),
        .sum_o (tree_sum)
    );

    always_comb begin
        logic [QW-1:0] s_ext, base, res;
        logic [QW:0]   sum;
        logic          ovfl;
        acc_d = acc_q;
        q_d   = q_q;
        qv_d  = 1'b0;
        ovf_d = ovf_q;
        base  = accf_q ? acc_q : '0;
        if (sgn_q) begin
            s_ext = {{GB{tree_sum[SW-1]}}, tree_sum};
            sum   = {base[QW-1], base} + {s_ext[QW-1], s_ext};
            ovfl  = sum[QW] ^ sum[QW-1];
            // Saturate toward the true sign held in the extra bit.
            if (ovfl) begin
                res = sum[QW] ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}};
            end else begin
                res = sum[QW-1:0];
            end
        end else begin
            s_ext = {{GB{1'b0}}, tree_sum};
            sum   = {1'b0, base} + {1'b0, s_ext};
            ovfl  = sum[QW];
            res   = ovfl ? {QW{1'b1}} : sum[QW-1:0];
        end
        unique case (op_q)
            OP_MAC: begin
                acc_d = res;
                q_d   = res;
                qv_d  = 1'b1;
                ovf_d = ovfl | (accf_q & ovf_q);
            end
            OP_READ: begin
                q_d  = {{(QW-WW){1'b0}}, rdat_q};
                qv_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int a = 0; a < NWORD; a++) begin
                    mem_q[b][a] <= '0;
                end
            end
            op_q   <= OP_NONE;
            sgn_q  <= 1'b0;
            accf_q <= 1'b0;
            prod_q <= '0;
            rdat_q <= '0;
            acc_q  <= '0;
            q_q    <= '0;
            qv_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (!WEB) begin
                mem_q[BANKA][ADRA] <= D;
            end
            op_q   <= op_d;
            sgn_q  <= SGN;
            accf_q <= ACC;
            prod_q <= prod_d;
            rdat_q <= mem_q[BANKB][ADRB];
            acc_q  <= acc_d;
            q_q    <= q_d;
            qv_q   <= qv_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Q   = q_q;
    assign QV  = qv_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_dcim_mac_array.sv
// Randomized and directed bench for dcim_mac_array against an arithmetic model.
module tb_dcim_mac_array;

    localparam int NBANK = 16;
    localparam int NWORD = 4;
    localparam int WW    = 8;
    localparam int XW    = 11;
    localparam int QW    = 27;
    localparam longint MASK = (64'sd1 <<< QW) - 1;

    logic                   CLK = 1'b0;
    logic                   RST;
    logic [3:0]             BANKA;
    logic [1:0]             ADRA;
    logic [WW-1:0]          D;
    logic                   WEB;
    logic [3:0]             BANKB;
    logic [1:0]             ADRB;
    logic                   REB;
    logic                   ENCB;
    logic [NBANK*XW-1:0]    XIN;
    logic                   SGN;
    logic                   ACC;
    logic [QW-1:0]          Q;
    logic                   QV;
    logic                   OVF;

    always #5 CLK = ~CLK;

    dcim_mac_array dut (
        .CLK   (CLK),
        .RST   (RST),
        .BANKA (BANKA),
        .ADRA  (ADRA),
        .D     (D),
        .WEB   (WEB),
        .BANKB (BANKB),
        .ADRB  (ADRB),
        .REB   (REB),
        .ENCB  (ENCB),
        .XIN   (XIN),
        .SGN   (SGN),
        .ACC   (ACC),
        .Q     (Q),
        .QV    (QV),
        .OVF   (OVF)
    );

    int total = 0;
    int bad   = 0;

    int unsigned mem_m [NBANK][NWORD];
    longint      acc_m = 0;
    longint      q_m   = 0;
    bit          ovf_m = 0;
    bit          pend_v = 0;
    longint      pend_q = 0;
    bit          pend_o = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint sval(input longint v, input int w, input bit s);
        if (s && v[w-1]) begin
            return v - (64'sd1 <<< w);
        end
        return v;
    endfunction

    // Model the op sampled at the coming edge, then check the previous one's result.
    task automatic tick(input string tag);
        bit     v = 0;
        bit     was_rst = RST;
        longint s, r, lo, hi;
        bit     cl;
        if (RST) begin
            foreach (mem_m[b, a]) mem_m[b][a] = 0;
            acc_m = 0;
            q_m   = 0;
            ovf_m = 0;
        end else begin
            if (!ENCB) begin
                s = 0;
                for (int b = 0; b < NBANK; b++) begin
                    s += sval(longint'(mem_m[b][ADRB]), WW, SGN) *
                         sval(longint'(XIN[b*XW +: XW]), XW, SGN);
                end
                r  = s + (ACC ? sval(acc_m, QW, SGN) : 64'sd0);
                lo = SGN ? -(64'sd1 <<< (QW - 1)) : 64'sd0;
                hi = SGN ? (64'sd1 <<< (QW - 1)) - 1 : MASK;
                cl = (r > hi) || (r < lo);
                if (r > hi) r = hi;
                if (r < lo) r = lo;
                ovf_m = cl || (ACC && ovf_m);
                acc_m = r & MASK;
                q_m   = acc_m;
                v     = 1;
            end else if (!REB) begin
                q_m = longint'(mem_m[BANKB][ADRB]);
                v   = 1;
            end
            if (!WEB) mem_m[BANKA][ADRA] = D;
        end
        @(posedge CLK);
        #1;
        if (was_rst) begin
            pend_v = 0;
            pend_q = 0;
            pend_o = 0;
        end
        chk({tag, ".qv"},  64'(QV),  64'(pend_v));
        chk({tag, ".q"},   64'(Q),   64'(pend_q));
        chk({tag, ".ovf"}, 64'(OVF), 64'(pend_o));
        pend_v = v;
        pend_q = q_m;
        pend_o = ovf_m;
    endtask

    task automatic idle();
        WEB  = 1'b1;
        REB  = 1'b1;
        ENCB = 1'b1;
        ACC  = 1'b0;
    endtask

    task automatic set_x(input int v);
        for (int b = 0; b < NBANK; b++) XIN[b*XW +: XW] = XW'(v);
    endtask

    task automatic fill_w0(input logic [WW-1:0] val, input string tag);
        for (int b = 0; b < NBANK; b++) begin
            WEB   = 1'b0;
            BANKA = 4'(b);
            ADRA  = 2'd0;
            D     = val;
            tick(tag);
        end
        WEB = 1'b1;
    endtask

    initial begin
        logic [WW-1:0] dat [3];
        logic [XW-1:0] xv;
        dat[0] = 8'hAA;
        dat[1] = 8'hB1;
        dat[2] = 8'hC2;
        RST = 1'b1;
        idle();
        BANKA = '0; ADRA = '0; D = '0;
        BANKB = '0; ADRB = '0; SGN = 1'b0;
        XIN = '0;
        tick("rst");
        tick("rst");
        RST = 1'b0;
        tick("idle");

        for (int i = 0; i < 3; i++) begin
            WEB = 1'b0; BANKA = 4'd0; ADRA = 2'(i); D = dat[i];
            tick("wr");
        end
        WEB = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                REB = 1'b0; BANKB = 4'd0; ADRB = 2'(i);
            end else begin
                idle();
            end
            tick("rd");
            if (i > 0) chk("r037", 64'(Q), 64'(dat[i-1]));
        end

        fill_w0(8'd1, "w1");
        ENCB = 1'b0; ADRB = 2'd0; SGN = 1'b0; ACC = 1'b0; set_x(2047);
        tick("mac_u");
        idle();
        tick("mac_u");
        chk("r038", 64'(Q), 64'd32752);

        fill_w0(8'hFF, "wff");
        ENCB = 1'b0; SGN = 1'b1; ACC = 1'b0; set_x(1);
        tick("mac_s");
        idle();
        tick("mac_s");
        chk("r039", 64'(Q), 64'(MASK - 15));

        SGN = 1'b0; set_x(2047);
        for (int i = 0; i < 17; i++) begin
            ENCB = 1'b0; ACC = (i != 0);
            tick("sat");
            if (i == 16) chk("r040_16", 64'(Q), 64'd133628160);
        end
        idle();
        tick("sat");
        chk("r040_17", 64'(Q), 64'd134217727);
        chk("r040_ovf", 64'(OVF), 64'd1);

        ENCB = 1'b0; ACC = 1'b1;
        tick("rst_fl");
        idle();
        RST = 1'b1;
        tick("rst_fl");
        chk("r042_qv", 64'(QV), 64'd0);
        chk("r042_q", 64'(Q), 64'd0);
        chk("r042_ovf", 64'(OVF), 64'd0);
        RST = 1'b0;
        tick("rst_fl");
        tick("rst_fl");

        WEB = 1'b0; BANKA = 4'd0; ADRA = 2'd1; D = 8'd3;
        tick("wr41");
        ENCB = 1'b0; REB = 1'b0; ADRB = 2'd1; SGN = 1'b0; ACC = 1'b0;
        WEB = 1'b0; BANKA = 4'd0; ADRA = 2'd1; D = 8'h7F; set_x(1);
        tick("coll");
        idle();
        tick("coll");
        chk("r041_q", 64'(Q), 64'd3);
        tick("coll");
        chk("r041_qv", 64'(QV), 64'd0);

        for (int n = 0; n < 400; n++) begin
            RST   = ($urandom_range(0, 63) == 0);
            WEB   = 1'($urandom_range(0, 1));
            BANKA = 4'($urandom_range(0, 15));
            ADRA  = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: D = 8'hFF;
                1: D = 8'h80;
                2: D = 8'h7F;
                default: D = 8'($urandom);
            endcase
            REB   = 1'($urandom_range(0, 1));
            ENCB  = 1'($urandom_range(0, 1));
            BANKB = 4'($urandom_range(0, 15));
            ADRB  = 2'($urandom_range(0, 3));
            SGN   = 1'($urandom_range(0, 1));
            ACC   = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < NBANK; b++) begin
                case ($urandom_range(0, 5))
                    0: xv = 11'h7FF;
                    1: xv = 11'h400;
                    2: xv = 11'h3FF;
                    default: xv = 11'($urandom);
                endcase
                XIN[b*XW +: XW] = xv;
            end
            tick("rnd");
        end
        RST = 1'b0;
        idle();
        tick("end");
        tick("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcim_mac_array.md
DCIM_MAC_ARRAY -- requirements
Module: dcim_mac_array

Interface
REQ-001 SHALL have parameter NBANK, default 16, number of weight banks (power of two, >=2).
REQ-002 SHALL have parameter NWORD, default 4, words per bank (power of two, >=2).
REQ-003 SHALL have parameter WW, default 8, weight width.
REQ-004 SHALL have parameter XW, default 11, per-bank input width.
REQ-005 SHALL have parameter GB, default 4, accumulator guard bits; QW = WW+XW+log2(NBANK)+GB.
REQ-006 SHALL have one clock and a synchronous, active-high reset; nothing else is clocked or reset asynchronously.
REQ-007 CLK  in  1  clock, all state updates on rising edge.
REQ-008 RST  in  1  synchronous active-high reset.
REQ-009 BANKA  in  log2(NBANK)  write bank select.
REQ-010 ADRA  in  log2(NWORD)  write word address.
REQ-011 D  in  WW  write data.
REQ-012 WEB  in  1  write enable, active-low.
REQ-013 BANKB  in  log2(NBANK)  read bank select.
REQ-014 ADRB  in  log2(NWORD)  read and compute word address.
REQ-015 REB  in  1  read enable, active-low.
REQ-016 ENCB  in  1  compute enable, active-low.
REQ-017 XIN  in  NBANK*XW  inputs; bank b uses XIN[b*XW +: XW].
REQ-018 SGN  in  1  1 = weights and inputs two's complement; 0 = unsigned.
REQ-019 ACC  in  1  1 = add result to accumulator; 0 = load fresh.
REQ-020 Q  out  QW  read data or MAC result.
REQ-021 QV  out  1  one-cycle pulse, Q updated.
REQ-022 OVF  out  1  sticky saturation flag.

Function
REQ-023 WEB=0 SHALL write D into word[BANKA][ADRA] at the rising edge.
REQ-024 Read (REB=0, ENCB=1) SHALL yield Q = word[BANKB][ADRB] zero-extended, QV=1, two cycles after the sampling edge.
REQ-025 Compute (ENCB=0) SHALL sample XIN, SGN, ACC and ADRB, then form S = sum over b of word[b][ADRB]*XIN_b, sign-extended per SGN.
REQ-026 Compute pipeline SHALL be: stage 1 registers the NBANK products; stage 2 forms the adder-tree sum and updates the accumulator; Q/QV two cycles after sampling; one op accepted per cycle.
REQ-027 ACC=0 SHALL load the accumulator with S; ACC=1 SHALL load accumulator+S; Q = new accumulator value.
REQ-028 On accumulation overflow the accumulator SHALL saturate to the max/min of QW bits (per SGN) and set OVF; OVF clears only on RST or an ACC=0 compute.
REQ-029 If ENCB=0 and REB=0 in the same cycle, compute SHALL win and the read is dropped.
REQ-030 Write and compute/read on the same word in the same cycle SHALL return the old (pre-write) weight.
REQ-031 With no op in flight, Q SHALL hold its last value and QV SHALL be 0.
REQ-032 A read result SHALL NOT modify the accumulator.

Reset
REQ-033 RST=1 SHALL clear every weight word, the pipeline valid bits, the accumulator, Q, QV and OVF to 0.
REQ-034 An op in flight when RST asserts SHALL be discarded, with no QV pulse after reset.

Structure
REQ-035 Shared package dcim_pkg SHALL hold the op-kind enum (NONE/READ/MAC) and the QW width function.
REQ-036 Sub-module dcim_adder_tree SHALL implement the parametrised NBANK-input signed/unsigned reduction.

Verification
REQ-037 Write AA,B1,C2 to bank0 words 0..2, then read them -> Q=0x0AA,0x0B1,0x0C2 on consecutive cycles, each 2 cycles after request, QV=1.
REQ-038 All addr-0 weights 1, XIN all 2047, SGN=0, ACC=0 -> Q=32752.
REQ-039 Weights 8'hFF, XIN all 1, SGN=1 -> Q=-16 (two's complement, QW bits).
REQ-040 Weights 255, XIN 2047, SGN=0, 17 back-to-back computes with ACC=1 (first ACC=0) -> 16th Q=133628160, 17th Q=134217727, OVF=1.
REQ-041 ENCB=0 and REB=0 together with a write to word[0][ADRB] -> MAC result uses old weight, no read QV.
REQ-042 RST asserted one cycle after a compute request -> no QV, Q=0, OVF=0.
